public_axi_rd_responder: RTL and testbench
==========================================

Name: public_axi_rd_responder

Overview:
- AXI4 read-channel responder (slave) that terminates AR/R transactions from an AXI read initiator, such as the IFU/MEM read arbiter.
- Backs the read channel with an external synchronous single-port SRAM (1-cycle read latency).
- Supports FIXED/INCR/WRAP bursts of up to 256 beats, a programmable first-beat delay, ID echo, and SLVERR generation.
- Used as the memory-side model in the core's standalone simulation top and as the RTL for on-chip ROM/SRAM slaves.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address decoded by this slave.
- MEM_BYTES, 32'h0800_0000, decoded window size in bytes; must be a multiple of 8.
- MEM_AW, 24, SRAM word-address width; 2^MEM_AW*8 >= MEM_BYTES.
- RD_DELAY, 0, extra idle cycles inserted after the AR handshake, before the first SRAM fetch (0..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- axi_arvalid  in  1  read address valid
- axi_arready  out  1  read address ready
- axi_araddr  in  32  byte address
- axi_arid  in  4  transaction ID
- axi_arlen  in  8  beats minus 1
- axi_arsize  in  3  log2 bytes per beat
- axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- axi_rvalid  out  1  read data valid
- axi_rready  in  1  read data ready
- axi_rdata  out  64  read data (full 64-bit word; the initiator selects byte lanes)
- axi_rresp  out  2  00 OKAY, 10 SLVERR
- axi_rlast  out  1  final beat of burst
- axi_rid  out  4  echo of latched arid
- sram_ren  out  1  SRAM read strobe
- sram_addr  out  MEM_AW  SRAM word address = (addr - BASE_ADDR) >> 3
- sram_rdata  in  64  valid from the cycle after sram_ren; held until the next sram_ren

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active high.
- Reset values:
  - state IDLE; axi_arready=1.
  - axi_rvalid=0, axi_rlast=0, axi_rresp=00, axi_rid=0, axi_rdata=0.
  - sram_ren=0, sram_addr=0.
  - rst asserted mid-burst aborts the burst; no further beats are issued.
- States: IDLE, DELAY, FETCH, RESP.
- IDLE:
  - axi_arready=1 in IDLE only.
  - On arvalid&arready, latch addr, id, len, size, burst; load beat counter=len and delay counter=RD_DELAY.
  - Next state is DELAY if RD_DELAY>0, else FETCH.
- DELAY: decrement the delay counter; go to FETCH when it reaches 1.
- FETCH (one cycle):
  - Compute err = addr outside [BASE_ADDR, BASE_ADDR+MEM_BYTES) | burst==11 | size>3 | (burst==WRAP & len not in {1,3,7,15}).
  - If err is clear, assert sram_ren and drive sram_addr.
  - Go to RESP.
- RESP:
  - axi_rvalid=1.
  - axi_rdata = sram_rdata if err clear, else 0.
  - axi_rresp = SLVERR if err, else OKAY.
  - axi_rlast = (beat counter==0).
  - All R outputs stay stable while rvalid & ~rready.
  - On rready with rlast: go to IDLE.
  - On rready without rlast: advance the address, decrement the beat counter, go to FETCH. No delay is inserted between beats.
- Latency:
  - RD_DELAY=0: AR handshake at cycle T gives first rvalid at T+2.
  - Each subsequent beat follows its predecessor's handshake by 2 cycles.
  - RD_DELAY=N shifts only the first beat by N cycles.
- Address advance (computed in 32 bits):
  - FIXED: address unchanged.
  - INCR: addr + (1<<size), wrapping modulo 2^32.
  - WRAP: with span = (len+1)<<size and low = addr & ~(span-1), next = addr + (1<<size); if next == low+span, next = low.
- Errors:
  - err is evaluated per beat. An INCR burst crossing the top of the window returns OKAY beats, then SLVERR beats.
  - Error beats never assert sram_ren.
  - The full arlen+1 beats are always returned.
- Unaligned araddr: sram_addr uses the word index; the data returned is the containing 64-bit word.
- axi_rid equals the latched arid for every beat of the burst.

Decomposition:
- Shared package DEFINES_ysyx23060136 holds:
  - state enum (IDLE/DELAY/FETCH/RESP);
  - burst encodings BURST_FIXED/INCR/WRAP;
  - response codes OKAY/SLVERR.
- Sub-module: public_axi_burst_addr_gen, combinational (addr, size, len, burst -> next_addr, err_fmt). Instantiated once.

Test Plan:
- araddr=0x8000_0010, len=0, size=2, INCR, id=3, rready=1, RD_DELAY=0 -> AR handshake at T; rvalid=1 at T+2; rdata = SRAM word 2; rresp=00; rlast=1; rid=3; arready=1 again at T+3.
- araddr=0x8000_0000, len=3, size=3, INCR, rready toggling 1/0 -> sram_addr sequence 0,1,2,3; R outputs stable while rready=0; rlast only on beat 4.
- WRAP, araddr=0x8000_0018, len=3, size=3 -> sram_addr sequence 3,0,1,2.
- araddr=0x8800_0000 (out of window), len=1 -> two beats, rresp=10, rdata=0, sram_ren never asserted.
- araddr=0x87FF_FFF8, len=1, size=3, INCR -> beat1 OKAY with sram_addr=0xFFFFFF, beat2 SLVERR.
- RD_DELAY=5 with rst asserted during RESP of beat 2 of a len=3 burst -> first rvalid at T+7; next cycle after rst: rvalid=0, arready=1, no further beats.

Source files
------------

// File: rtl/public_axi_rd_responder_pkg.sv
// Shared types and encodings for the AXI4 read-channel responder.
package public_axi_rd_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StFetch,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/public_axi_rd_responder_if.sv
// AR/R channel plus the SRAM read port of the read responder.
interface public_axi_rd_responder_if #(
  parameter int unsigned MEM_AW = 24
) ();

  logic              axi_arvalid;
  logic              axi_arready;
  logic [31:0]       axi_araddr;
  logic [3:0]        axi_arid;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [63:0]       axi_rdata;
  logic [1:0]        axi_rresp;
  logic              axi_rlast;
  logic [3:0]        axi_rid;
  logic              sram_ren;
  logic [MEM_AW-1:0] sram_addr;
  logic [63:0]       sram_rdata;

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
    input  axi_rready, sram_rdata,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
    output sram_ren, sram_addr
  );

  modport master (
    output axi_arvalid, axi_araddr, axi_arid, axi_arlen, axi_arsize, axi_arburst,
    output axi_rready, sram_rdata,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast, axi_rid,
    input  sram_ren, sram_addr
  );

endinterface

// File: rtl/public_axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts and burst-format error detection.
module public_axi_burst_addr_gen
  import public_axi_rd_responder_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        err_fmt
);

  logic [31:0] step;
  logic [31:0] span;
  logic [31:0] low;
  logic [31:0] incr;

  always_comb begin
    step = 32'd1 << size;
    span = (32'(len) + 32'd1) << size;
    low  = addr & ~(span - 32'd1);
    incr = addr + step;
    case (burst)
      BurstFixed: next_addr = addr;
      BurstIncr:  next_addr = incr;
      BurstWrap:  next_addr = (incr == low + span) ? low : incr;
      default:    next_addr = addr;
    endcase
    err_fmt = (burst == BurstRsvd) || (size > 3'd3) ||
              ((burst == BurstWrap) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  end

endmodule

// File: rtl/public_axi_rd_responder.sv
// AXI4 read responder backed by a 1-cycle-latency synchronous SRAM.
module public_axi_rd_responder
  import public_axi_rd_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0800_0000,
  parameter int unsigned MEM_AW    = 24,
  parameter int unsigned RD_DELAY  = 0
) (
  input logic                        clk,
  input logic                        rst,
  public_axi_rd_responder_if.slave   bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  dly_q, dly_d;
  logic        err_q, err_d;

  logic [31:0] next_addr;
  logic        err_fmt;
  logic [31:0] offset;
  logic        in_window;
  logic        err_beat;

  public_axi_burst_addr_gen u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .err_fmt   (err_fmt)
  );

  // Offset compare stays correct even if BASE_ADDR + MEM_BYTES overflows 32 bits.
  assign offset    = addr_q - BASE_ADDR;
  assign in_window = (addr_q >= BASE_ADDR) && (offset < MEM_BYTES);
  assign err_beat  = !in_window || err_fmt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      dly_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      dly_q   <= dly_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    dly_d   = dly_q;
    err_d   = err_q;

    bus.axi_arready = 1'b0;
    bus.axi_rvalid  = 1'b0;
    bus.axi_rdata   = '0;
    bus.axi_rresp   = RespOkay;
    bus.axi_rlast   = 1'b0;
    bus.axi_rid     = id_q;
    bus.sram_ren    = 1'b0;
    bus.sram_addr   = '0;

    unique case (state_q)
      StIdle: begin
        bus.axi_arready = 1'b1;
        if (bus.axi_arvalid) begin
          addr_d  = bus.axi_araddr;
          id_d    = bus.axi_arid;
          len_d   = bus.axi_arlen;
          size_d  = bus.axi_arsize;
          burst_d = bus.axi_arburst;
          beat_d  = bus.axi_arlen;
          dly_d   = 8'(RD_DELAY);
          state_d = (RD_DELAY > 0) ? StDelay : StFetch;
        end
      end
      StDelay: begin
        dly_d = dly_q - 8'd1;
        if (dly_q <= 8'd1) state_d = StFetch;
      end
      StFetch: begin
        err_d = err_beat;
        if (!err_beat) begin
          bus.sram_ren  = 1'b1;
          bus.sram_addr = offset[3 +: MEM_AW];
        end
        state_d = StResp;
      end
      StResp: begin
        // sram_rdata is held by the SRAM until the next read, so R stays stable under stall.
        bus.axi_rvalid = 1'b1;
        bus.axi_rdata  = err_q ? 64'd0 : bus.sram_rdata;
        bus.axi_rresp  = err_q ? RespSlverr : RespOkay;
        bus.axi_rlast  = (beat_q == 8'd0);
        if (bus.axi_rready) begin
          if (beat_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            addr_d  = next_addr;
            beat_d  = beat_q - 8'd1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_public_axi_rd_responder.sv
// Directed, table-driven bench for the AXI read responder with an SRAM model.
module tb_public_axi_rd_responder;
  import public_axi_rd_responder_pkg::*;

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic             stall;
    logic [3:0][23:0] widx;
    logic [3:0]       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  public_axi_rd_responder_if #(.MEM_AW(24)) bus0 ();
  public_axi_rd_responder_if #(.MEM_AW(24)) bus1 ();

  public_axi_rd_responder #(.RD_DELAY(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  public_axi_rd_responder #(.RD_DELAY(5)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  function automatic logic [63:0] word(input logic [23:0] a);
    return {8'hA5, a, 8'h3C, a};
  endfunction

  always @(posedge clk) if (bus0.sram_ren) bus0.sram_rdata <= word(bus0.sram_addr);
  always @(posedge clk) if (bus1.sram_ren) bus1.sram_rdata <= word(bus1.sram_addr);

  function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [3:0] id, input logic stall,
                              input logic [23:0] w0, input logic [23:0] w1,
                              input logic [23:0] w2, input logic [23:0] w3,
                              input logic [3:0] err);
    vec_t v;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.stall = stall; v.err = err;
    v.widx[0] = w0; v.widx[1] = w1; v.widx[2] = w2; v.widx[3] = w3;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    logic        got_ren;
    logic [23:0] ren_addr;
    logic        e;
    logic [63:0] snap;
    @(negedge clk);
    check("arready_idle", bus0.axi_arready, 64'd1);
    bus0.axi_arvalid = 1'b1;
    bus0.axi_araddr  = v.addr;
    bus0.axi_arid    = v.id;
    bus0.axi_arlen   = v.len;
    bus0.axi_arsize  = v.size;
    bus0.axi_arburst = v.burst;
    @(posedge clk);
    #1 bus0.axi_arvalid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      lat = 0;
      got_ren = 1'b0;
      ren_addr = '0;
      while (!bus0.axi_rvalid && lat < 40) begin
        @(negedge clk);
        lat++;
        if (bus0.sram_ren) begin
          got_ren = 1'b1;
          ren_addr = bus0.sram_addr;
        end
      end
      e = v.err[b];
      check("beat_latency", 64'(lat), 64'd2);
      check("sram_ren", got_ren, !e);
      if (!e) check("sram_addr", ren_addr, v.widx[b]);
      check("rresp", bus0.axi_rresp, e ? 64'd2 : 64'd0);
      check("rdata", bus0.axi_rdata, e ? 64'd0 : word(v.widx[b]));
      check("rlast", bus0.axi_rlast, (b == int'(v.len)) ? 64'd1 : 64'd0);
      check("rid", bus0.axi_rid, v.id);
      if (v.stall) begin
        snap = bus0.axi_rdata;
        bus0.axi_rready = 1'b0;
        @(negedge clk);
        check("stall_rvalid", bus0.axi_rvalid, 64'd1);
        check("stall_rdata", bus0.axi_rdata, snap);
        check("stall_rlast", bus0.axi_rlast, (b == int'(v.len)) ? 64'd1 : 64'd0);
        check("stall_ren", bus0.sram_ren, 64'd0);
      end
      bus0.axi_rready = 1'b1;
      @(posedge clk);
      #1 bus0.axi_rready = 1'b0;
    end
    @(negedge clk);
    check("arready_after", bus0.axi_arready, 64'd1);
    check("rvalid_after", bus0.axi_rvalid, 64'd0);
  endtask

  initial begin
    int lat;
    int n_rv;
    int n_ren;
    vecs[0]  = mk(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'd3,  1'b0, 24'd2, 0, 0, 0, 4'b0000);
    vecs[1]  = mk(32'h8000_0000, 8'd3, 3'd3, 2'b01, 4'd7,  1'b1, 24'd0, 1, 2, 3, 4'b0000);
    vecs[2]  = mk(32'h8000_0018, 8'd3, 3'd3, 2'b10, 4'd1,  1'b0, 24'd3, 0, 1, 2, 4'b0000);
    vecs[3]  = mk(32'h8800_0000, 8'd1, 3'd3, 2'b01, 4'd2,  1'b0, 24'd0, 0, 0, 0, 4'b0011);
    vecs[4]  = mk(32'h87FF_FFF8, 8'd1, 3'd3, 2'b01, 4'd9,  1'b0, 24'hFF_FFFF, 0, 0, 0, 4'b0010);
    vecs[5]  = mk(32'h8000_0040, 8'd0, 3'd3, 2'b11, 4'd4,  1'b0, 24'd0, 0, 0, 0, 4'b0001);
    vecs[6]  = mk(32'h8000_0000, 8'd2, 3'd3, 2'b10, 4'd6,  1'b0, 24'd0, 0, 0, 0, 4'b0111);
    vecs[7]  = mk(32'h8000_0028, 8'd2, 3'd3, 2'b00, 4'd10, 1'b1, 24'd5, 5, 5, 0, 4'b0000);
    vecs[8]  = mk(32'h8000_0000, 8'd0, 3'd4, 2'b01, 4'd11, 1'b0, 24'd0, 0, 0, 0, 4'b0001);
    vecs[9]  = mk(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 4'd12, 1'b0, 24'd0, 0, 0, 0, 4'b0001);
    vecs[10] = mk(32'h8000_001C, 8'd1, 3'd2, 2'b01, 4'd13, 1'b0, 24'd3, 4, 0, 0, 4'b0000);
    vecs[11] = mk(32'h8000_0008, 8'd1, 3'd3, 2'b10, 4'd14, 1'b1, 24'd1, 0, 0, 0, 4'b0000);

    rst = 1'b1;
    bus0.axi_arvalid = 1'b0; bus0.axi_araddr = '0; bus0.axi_arid = '0; bus0.axi_arlen = '0;
    bus0.axi_arsize = '0; bus0.axi_arburst = '0; bus0.axi_rready = 1'b0;
    bus1.axi_arvalid = 1'b0; bus1.axi_araddr = '0; bus1.axi_arid = '0; bus1.axi_arlen = '0;
    bus1.axi_arsize = '0; bus1.axi_arburst = '0; bus1.axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arready", bus0.axi_arready, 64'd1);
    check("rst_rvalid", bus0.axi_rvalid, 64'd0);
    check("rst_rlast", bus0.axi_rlast, 64'd0);
    check("rst_rresp", bus0.axi_rresp, 64'd0);
    check("rst_rid", bus0.axi_rid, 64'd0);
    check("rst_rdata", bus0.axi_rdata, 64'd0);
    check("rst_sram_ren", bus0.sram_ren, 64'd0);
    check("rst_sram_addr", bus0.sram_addr, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // RD_DELAY=5 instance: first-beat latency, then reset during beat 2 of a 4-beat burst.
    @(negedge clk);
    bus1.axi_arvalid = 1'b1; bus1.axi_araddr = 32'h8000_0000; bus1.axi_arid = 4'd5;
    bus1.axi_arlen = 8'd3; bus1.axi_arsize = 3'd3; bus1.axi_arburst = 2'b01;
    bus1.axi_rready = 1'b1;
    @(posedge clk);
    #1 bus1.axi_arvalid = 1'b0;
    lat = 0;
    while (!bus1.axi_rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("dly_first_latency", 64'(lat), 64'd7);
    check("dly_b1_rdata", bus1.axi_rdata, word(24'd0));
    check("dly_b1_rid", bus1.axi_rid, 64'd5);
    @(posedge clk);
    #1 bus1.axi_rready = 1'b0;
    lat = 0;
    while (!bus1.axi_rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("dly_b2_latency", 64'(lat), 64'd2);
    check("dly_b2_rdata", bus1.axi_rdata, word(24'd1));
    check("dly_b2_rlast", bus1.axi_rlast, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_rvalid", bus1.axi_rvalid, 64'd0);
    check("abort_arready", bus1.axi_arready, 64'd1);
    bus1.axi_rready = 1'b1;
    n_rv = 0;
    n_ren = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus1.axi_rvalid) n_rv++;
      if (bus1.sram_ren) n_ren++;
    end
    check("abort_no_beats", 64'(n_rv), 64'd0);
    check("abort_no_reads", 64'(n_ren), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
